// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcode constants, EX state encoding and the
// multicycle predicate used by both this issue block and the vector ALU.
package alu_issue_ctrl_pkg;

    localparam logic [5:0] ALU_OP_MC_A = 6'b000101;
    localparam logic [5:0] ALU_OP_MC_B = 6'b000110;
    localparam logic [5:0] ALU_OP_MC_C = 6'b000111;
    localparam logic [5:0] ALU_OP_MC_D = 6'b001000;

    localparam logic [1:0] WW_64 = 2'b11;

    typedef enum logic [1:0] {
        EX_IDLE   = 2'd0,
        EX_SINGLE = 2'd1,
        EX_MULTI  = 2'd2
    } ex_state_e;

    // The ALU picks its slow datapath with this same rule, so the issue
    // block and the ALU always agree on how long a result takes.
    function automatic logic is_multicycle(
        input logic [5:0] alu_type,
        input logic [1:0] ww
    );
        logic ab_wide;
        ab_wide = ((alu_type == ALU_OP_MC_A) || (alu_type == ALU_OP_MC_B))
                  && (ww == WW_64);
        return ab_wide || (alu_type == ALU_OP_MC_C)
                       || (alu_type == ALU_OP_MC_D);
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// alu_lat_counter: remaining-cycle counter for a multicycle ALU op.
// Ports: clk, reset (sync, high), clear (flush), load/load_multi (issue),
// dec (EX in MULTI), zero_o (no cycles left).
module alu_lat_counter #(
    parameter int MULT_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic load,
    input  logic load_multi,
    input  logic dec,
    output logic zero_o
);

    localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MULT_LAT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_multi ? LOAD_VAL : '0;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: EX-stage issue/sequencing for the vector ALU. Registers
// ID operands into EX, holds EX for multicycle ops (stalling ID via
// id_ready), and captures alu_dout with its tags into the EX/WB register.
// Ports: clk, reset (sync, high), flush; id_* in, id_ready out; aluEN and
// EX copies to the ALU; alu_dout from the ALU; wb_* out.
// Optional ALU_STALL_CNT_EN adds stall_cnt (saturating ID stall count).
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DW       = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [5:0]    id_aluType,
    input  logic [1:0]    id_ww,
    input  logic [4:0]    id_imm,
    input  logic [DW-1:0] id_oprA,
    input  logic [DW-1:0] id_oprB,
    input  logic [4:0]    id_rd,
    input  logic [2:0]    id_ppp,
    input  logic          id_wrEn,
    output logic          aluEN,
    output logic [5:0]    aluType,
    output logic [1:0]    ww,
    output logic [4:0]    imm,
    output logic [DW-1:0] oprA,
    output logic [DW-1:0] oprB,
    input  logic [DW-1:0] alu_dout,
    output logic          wb_valid,
    output logic [DW-1:0] wb_data,
    output logic [4:0]    wb_rd,
    output logic [2:0]    wb_ppp,
    output logic          wb_wrEn
`ifdef ALU_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    ex_state_e     state_q;
    ex_state_e     state_d;

    logic [5:0]    ex_type_q;
    logic [1:0]    ex_ww_q;
    logic [4:0]    ex_imm_q;
    logic [DW-1:0] ex_a_q;
    logic [DW-1:0] ex_b_q;
    logic [4:0]    ex_rd_q;
    logic [2:0]    ex_ppp_q;
    logic          ex_wren_q;

    logic          wb_valid_q;
    logic [DW-1:0] wb_data_q;
    logic [4:0]    wb_rd_q;
    logic [2:0]    wb_ppp_q;
    logic          wb_wren_q;

    logic          cnt_zero;
    logic          done;
    logic          issue;
    logic          id_multi;

    alu_lat_counter #(
        .MULT_LAT (MULT_LAT)
    ) u_lat_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear      (flush),
        .load       (issue),
        .load_multi (id_multi),
        .dec        (state_q == EX_MULTI),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        id_multi = is_multicycle(id_aluType, id_ww);
        done     = (state_q == EX_SINGLE) ||
                   ((state_q == EX_MULTI) && cnt_zero);
        id_ready = (state_q == EX_IDLE) || done;
        // ID is ignored during flush so nothing slips into a killed EX.
        issue    = id_valid && id_ready && !flush;
    end

    // With MULT_LAT=1 the counter loads 0, so MULTI is done at once and
    // behaves exactly like SINGLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EX_IDLE;
        end else if (issue) begin
            state_d = id_multi ? EX_MULTI : EX_SINGLE;
        end else if (done) begin
            state_d = EX_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EX_IDLE;
            ex_type_q  <= '0;
            ex_ww_q    <= '0;
            ex_imm_q   <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_rd_q    <= '0;
            ex_ppp_q   <= '0;
            ex_wren_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_ppp_q   <= '0;
            wb_wren_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                ex_type_q <= id_aluType;
                ex_ww_q   <= id_ww;
                ex_imm_q  <= id_imm;
                ex_a_q    <= id_oprA;
                ex_b_q    <= id_oprB;
                ex_rd_q   <= id_rd;
                ex_ppp_q  <= id_ppp;
                ex_wren_q <= id_wrEn;
            end
            if (flush) begin
                wb_valid_q <= 1'b0;
            end else if (done) begin
                wb_valid_q <= 1'b1;
                wb_data_q  <= alu_dout;
                wb_rd_q    <= ex_rd_q;
                wb_ppp_q   <= ex_ppp_q;
                wb_wren_q  <= ex_wren_q;
            end else begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    assign aluEN    = (state_q != EX_IDLE);
    assign aluType  = ex_type_q;
    assign ww       = ex_ww_q;
    assign imm      = ex_imm_q;
    assign oprA     = ex_a_q;
    assign oprB     = ex_b_q;
    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_rd    = wb_rd_q;
    assign wb_ppp   = wb_ppp_q;
    assign wb_wrEn  = wb_wren_q;

`ifdef ALU_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (id_valid && !id_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a simple
// combinational ALU model driven from the EX outputs.
module tb_alu_issue_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DW       = 64;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [5:0]    id_aluType;
    logic [1:0]    id_ww;
    logic [4:0]    id_imm;
    logic [DW-1:0] id_oprA;
    logic [DW-1:0] id_oprB;
    logic [4:0]    id_rd;
    logic [2:0]    id_ppp;
    logic          id_wrEn;
    logic          aluEN;
    logic [5:0]    aluType;
    logic [1:0]    ww;
    logic [4:0]    imm;
    logic [DW-1:0] oprA;
    logic [DW-1:0] oprB;
    logic [DW-1:0] alu_dout;
    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_rd;
    logic [2:0]    wb_ppp;
    logic          wb_wrEn;
`ifdef ALU_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    alu_issue_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DW       (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_aluType (id_aluType),
        .id_ww      (id_ww),
        .id_imm     (id_imm),
        .id_oprA    (id_oprA),
        .id_oprB    (id_oprB),
        .id_rd      (id_rd),
        .id_ppp     (id_ppp),
        .id_wrEn    (id_wrEn),
        .aluEN      (aluEN),
        .aluType    (aluType),
        .ww         (ww),
        .imm        (imm),
        .oprA       (oprA),
        .oprB       (oprB),
        .alu_dout   (alu_dout),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_ppp     (wb_ppp),
        .wb_wrEn    (wb_wrEn)
`ifdef ALU_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // ALU model: result depends on opcode and both operands.
    assign alu_dout = (oprA + oprB) ^ {{(DW-6){1'b0}}, aluType};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic [4:0]    rd;
        logic [2:0]    ppp;
        logic          wren;
        int            due;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (wb_valid) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL wb_unexpected: wb_valid=1 rd=%0d at cycle %0d, required no result",
                             wb_rd, cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc !== e.due) begin
                        n_errors++;
                        $display("FAIL wb_timing: cycle %0d, required %0d", cyc, e.due);
                    end
                    n_checks++;
                    if (wb_data !== e.data || wb_rd !== e.rd ||
                        wb_ppp !== e.ppp || wb_wrEn !== e.wren) begin
                        n_errors++;
                        $display("FAIL wb_data: got %h/%0d/%0d/%0d, required %h/%0d/%0d/%0d",
                                 wb_data, wb_rd, wb_ppp, wb_wrEn,
                                 e.data, e.rd, e.ppp, e.wren);
                    end
                end
            end else if (q.size() != 0 && cyc >= q[0].due) begin
                n_checks++;
                n_errors++;
                $display("FAIL wb_missing: no wb_valid at cycle %0d, required rd=%0d",
                         cyc, q[0].rd);
                void'(q.pop_front());
            end
        end
    endtask

    // Starts at a negedge; returns at the negedge after the issue edge.
    task automatic issue_op(
        input  logic [5:0]    t,
        input  logic [1:0]    w,
        input  logic [DW-1:0] a,
        input  logic [DW-1:0] b,
        input  logic [4:0]    rd,
        input  logic [2:0]    ppp,
        input  logic          we,
        input  int            lat,
        output int            stalls
    );
        exp_t e;
        stalls     = 0;
        id_valid   = 1'b1;
        id_aluType = t;
        id_ww      = w;
        id_imm     = rd;
        id_oprA    = a;
        id_oprB    = b;
        id_rd      = rd;
        id_ppp     = ppp;
        id_wrEn    = we;
        #1;
        while (!id_ready && stalls < 40) begin
            n_checks++;
            if (oprA !== last_a || oprB !== last_b) begin
                n_errors++;
                $display("FAIL ex_hold: oprA=%h oprB=%h, required %h %h",
                         oprA, oprB, last_a, last_b);
            end
            stalls++;
            @(negedge clk);
            #1;
        end
        n_checks++;
        if (!id_ready) begin
            n_errors++;
            $display("FAIL issue_timeout: id_ready=0 after %0d cycles, required 1", stalls);
        end
        e.data = (a + b) ^ {{(DW-6){1'b0}}, t};
        e.rd   = rd;
        e.ppp  = ppp;
        e.wren = we;
        e.due  = cyc + 1 + lat;
        q.push_back(e);
        last_a = a;
        last_b = b;
        @(negedge clk);
        id_valid = 1'b0;
        n_checks++;
        if (aluType !== t || oprA !== a || oprB !== b || !aluEN) begin
            n_errors++;
            $display("FAIL ex_load: type=%b a=%h en=%0d, required %b %h 1",
                     aluType, oprA, aluEN, t, a);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_stalls(input string name, input int got, input int req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: stalls=%0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_idle(input string name);
        n_checks++;
        if (aluEN !== 1'b0 || id_ready !== 1'b1 || wb_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: aluEN=%0d id_ready=%0d wb_valid=%0d, required 0 1 0",
                     name, aluEN, id_ready, wb_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle("reset_state");
        n_checks++;
        if (wb_data !== '0 || wb_rd !== '0 || wb_ppp !== '0 || wb_wrEn !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_wb: data=%h rd=%0d ppp=%0d we=%0d, required all 0",
                     wb_data, wb_rd, wb_ppp, wb_wrEn);
        end
`ifdef ALU_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_stall_cnt: %0d, required 0", stall_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int s;
        for (int i = 1; i <= 3; i++) begin
            issue_op(6'b000001, 2'b00, 64'h1000 * i, 64'h0f0f_0000_0000_0000 + i,
                     5'(i), 3'(i), 1'b1, 1, s);
            check_stalls("b2b_ready", s, 0);
        end
        drain();
    endtask

    task automatic test_multicycle();
        int s;
        issue_op(6'b000101, 2'b11, 64'hdead_beef_0000_0001, 64'h1234_5678_9abc_def0,
                 5'd10, 3'd5, 1'b1, MULT_LAT, s);
        check_stalls("mc_first", s, 0);
        issue_op(6'b000001, 2'b00, 64'h55, 64'haa, 5'd11, 3'd2, 1'b0, 1, s);
        check_stalls("mc_queued", s, MULT_LAT - 1);
        drain();
`ifdef ALU_STALL_CNT_EN
        n_checks++;
        if (stall_cnt !== 32'(MULT_LAT - 1)) begin
            n_errors++;
            $display("FAIL stall_cnt: %0d, required %0d", stall_cnt, MULT_LAT - 1);
        end
`endif
    endtask

    task automatic test_ww();
        int s;
        issue_op(6'b000101, 2'b10, 64'h7, 64'h9, 5'd12, 3'd1, 1'b1, 1, s);
        issue_op(6'b000001, 2'b00, 64'h3, 64'h4, 5'd13, 3'd1, 1'b1, 1, s);
        check_stalls("ww10_nostall", s, 0);
        drain();
        issue_op(6'b000101, 2'b11, 64'h7, 64'h9, 5'd14, 3'd3, 1'b1, MULT_LAT, s);
        issue_op(6'b000001, 2'b00, 64'h3, 64'h4, 5'd15, 3'd3, 1'b1, 1, s);
        check_stalls("ww11_stall", s, MULT_LAT - 1);
        drain();
    endtask

    task automatic test_other_multi();
        int s;
        issue_op(6'b000111, 2'b00, 64'h100, 64'h200, 5'd16, 3'd4, 1'b1, MULT_LAT, s);
        issue_op(6'b001000, 2'b01, 64'h300, 64'h400, 5'd17, 3'd6, 1'b0, MULT_LAT, s);
        check_stalls("op07_stall", s, MULT_LAT - 1);
        issue_op(6'b000110, 2'b11, 64'h500, 64'h600, 5'd18, 3'd7, 1'b1, MULT_LAT, s);
        check_stalls("op08_stall", s, MULT_LAT - 1);
        drain();
    endtask

    task automatic test_flush();
        int s;
        issue_op(6'b000101, 2'b11, 64'hf1, 64'hf2, 5'd20, 3'd1, 1'b1, MULT_LAT, s);
        @(negedge clk);
        flush      = 1'b1;
        id_valid   = 1'b1;
        id_aluType = 6'b000001;
        id_ww      = 2'b00;
        id_rd      = 5'd31;
        @(negedge clk);
        flush    = 1'b0;
        id_valid = 1'b0;
        q.delete();
        check_idle("flush_idle");
        issue_op(6'b000001, 2'b00, 64'h21, 64'h22, 5'd21, 3'd2, 1'b1, 1, s);
        check_stalls("flush_next", s, 0);
        drain();
    endtask

    task automatic test_reset_mid();
        int s;
        issue_op(6'b001000, 2'b00, 64'hab, 64'hcd, 5'd22, 3'd3, 1'b1, MULT_LAT, s);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        check_idle("reset_mid_idle");
        repeat (6) @(negedge clk);
        issue_op(6'b000010, 2'b00, 64'h31, 64'h32, 5'd23, 3'd4, 1'b0, 1, s);
        check_stalls("reset_mid_next", s, 0);
        drain();
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        id_valid   = 1'b0;
        id_aluType = '0;
        id_ww      = '0;
        id_imm     = '0;
        id_oprA    = '0;
        id_oprB    = '0;
        id_rd      = '0;
        id_ppp     = '0;
        id_wrEn    = 1'b0;
        test_reset();
        fork
            monitor();
        join_none
        test_back_to_back();
        test_multicycle();
        test_ww();
        test_other_multi();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
